// File: rtl/branch_resolution_queue_if.sv
// Decode/execute/feedback bundle for the branch resolution queue.
// master drives decode pushes and execute resolutions; slave is the queue.
interface branch_resolution_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic                  dec_valid;
    logic [ADDR_WIDTH-1:0] dec_pc;
    logic                  dec_prediction;
    logic [ADDR_WIDTH-1:0] dec_recovery;
    logic                  dec_ready;
    logic                  ex_valid;
    logic                  ex_outcome;
    logic                  flush;
    logic                  fb_valid;
    logic [ADDR_WIDTH-1:0] fb_pc;
    logic                  fb_prediction;
    logic                  fb_outcome;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [OW-1:0]         occupancy;
    logic [CNT_WIDTH-1:0]  stat_resolved;
    logic [CNT_WIDTH-1:0]  stat_mispredict;
    logic                  err_overflow;
    logic                  err_underflow;

    modport master (
        output dec_valid, dec_pc, dec_prediction, dec_recovery,
        output ex_valid, ex_outcome, flush,
        input  dec_ready, fb_valid, fb_pc, fb_prediction, fb_outcome,
        input  redirect_valid, redirect_target, occupancy,
        input  stat_resolved, stat_mispredict, err_overflow, err_underflow
    );

    modport slave (
        input  dec_valid, dec_pc, dec_prediction, dec_recovery,
        input  ex_valid, ex_outcome, flush,
        output dec_ready, fb_valid, fb_pc, fb_prediction, fb_outcome,
        output redirect_valid, redirect_target, occupancy,
        output stat_resolved, stat_mispredict, err_overflow, err_underflow
    );
endinterface

// File: rtl/branch_resolution_queue.sv
// In-order queue of decode-time branch predictions, popped at execute
// to drive predictor feedback and mispredict redirects.
module branch_resolution_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input logic clk,
    input logic rst_n,
    branch_resolution_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];
    logic                  r_pred [DEPTH];
    logic [ADDR_WIDTH-1:0] r_rec  [DEPTH];
    logic [PW-1:0]         r_rd;
    logic [PW-1:0]         r_wr;
    logic [OW-1:0]         r_occ;

    logic                  r_fb_valid;
    logic [ADDR_WIDTH-1:0] r_fb_pc;
    logic                  r_fb_pred;
    logic                  r_fb_out;
    logic                  r_rd_valid;
    logic [ADDR_WIDTH-1:0] r_rd_target;
    logic [CNT_WIDTH-1:0]  r_resolved;
    logic [CNT_WIDTH-1:0]  r_mispred;
    logic                  r_ovf;
    logic                  r_unf;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_mis;
    logic w_kill;

    assign w_full  = (r_occ == FULL);
    assign w_empty = (r_occ == '0);
    assign w_push  = bus.dec_valid && !w_full;
    assign w_pop   = bus.ex_valid && !w_empty;
    assign w_mis   = w_pop && (bus.ex_outcome != r_pred[r_rd]);
    // Anything pushed alongside a squash belongs to the wrong path.
    assign w_kill  = w_mis || bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_occ       <= '0;
            r_fb_valid  <= 1'b0;
            r_fb_pc     <= '0;
            r_fb_pred   <= 1'b0;
            r_fb_out    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_target <= '0;
            r_resolved  <= '0;
            r_mispred   <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_fb_valid <= w_pop;
            r_rd_valid <= w_mis;
            if (w_pop) begin
                r_fb_pc   <= r_pc[r_rd];
                r_fb_pred <= r_pred[r_rd];
                r_fb_out  <= bus.ex_outcome;
                if (r_resolved != '1)
                    r_resolved <= r_resolved + 1'b1;
            end
            if (w_mis) begin
                r_rd_target <= r_rec[r_rd];
                if (r_mispred != '1)
                    r_mispred <= r_mispred + 1'b1;
            end
            if (w_kill) begin
                r_rd  <= r_wr;
                r_occ <= '0;
            end else begin
                if (w_push) begin
                    r_pc[r_wr]   <= bus.dec_pc;
                    r_pred[r_wr] <= bus.dec_prediction;
                    r_rec[r_wr]  <= bus.dec_recovery;
                    r_wr         <= r_wr + 1'b1;
                end
                if (w_pop)
                    r_rd <= r_rd + 1'b1;
                r_occ <= r_occ + OW'(w_push) - OW'(w_pop);
            end
            if (bus.dec_valid && w_full)
                r_ovf <= 1'b1;
            if (bus.ex_valid && w_empty)
                r_unf <= 1'b1;
        end
    end

    assign bus.dec_ready       = !w_full;
    assign bus.fb_valid        = r_fb_valid;
    assign bus.fb_pc           = r_fb_pc;
    assign bus.fb_prediction   = r_fb_pred;
    assign bus.fb_outcome      = r_fb_out;
    assign bus.redirect_valid  = r_rd_valid;
    assign bus.redirect_target = r_rd_target;
    assign bus.occupancy       = r_occ;
    assign bus.stat_resolved   = r_resolved;
    assign bus.stat_mispredict = r_mispred;
    assign bus.err_overflow    = r_ovf;
    assign bus.err_underflow   = r_unf;
endmodule
